// File: rtl/fetch_scheduler_if.sv
// I-cache fetch port bundle.
//   master (fetch_scheduler): drives ic_req/ic_addr, receives ic_ready and in-order responses.
//   slave  (I-cache)        : mirror of master.
//   ic_req          request valid; handshake = ic_req && ic_ready
//   ic_addr         fetch address of the dual-word request
//   ic_ready        I-cache accepts the request this cycle
//   ic_resp_valid   response for the oldest accepted request
//   ic_resp_data1/2 instruction words at ic_addr / ic_addr+4
interface fetch_scheduler_if;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_ready;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_data1;
  logic [31:0] ic_resp_data2;

  modport master (
    output ic_req, ic_addr,
    input  ic_ready, ic_resp_valid, ic_resp_data1, ic_resp_data2
  );

  modport slave (
    input  ic_req, ic_addr,
    output ic_ready, ic_resp_valid, ic_resp_data1, ic_resp_data2
  );
endinterface

// File: rtl/fetch_scheduler.sv
// Fetch scheduler: issues dual-word I-cache fetches from a local PC, reserves instruction-FIFO
// space with a credit counter, writes responses into the FIFO and handles branch redirects by
// flushing the FIFO and draining stale in-flight responses.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   redirect_valid, redirect_pc   single-cycle redirect pulse and word-aligned target
//   ic                            I-cache port (fetch_scheduler_if.master)
//   fifo_read_en1/2, fifo_empty   FIFO read strobes from issue; empty masks them
//   fifo_flush                    one-cycle FIFO reset, registered from redirect_valid
//   fifo_write_en/data/address1/2 registered FIFO write port (slot 1 and slot 2)
// Optional: define FETCH_SCHED_PERF_EN to add perf_stall_cycles and perf_discards counters.
module fetch_scheduler #(
  parameter logic [31:0] RESET_PC     = 32'hBFC0_0000,
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned MAX_INFLIGHT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  fetch_scheduler_if.master      ic,
  input  logic                   fifo_read_en1,
  input  logic                   fifo_read_en2,
  input  logic                   fifo_empty,
  output logic                   fifo_flush,
  output logic                   fifo_write_en1,
  output logic                   fifo_write_en2,
  output logic [31:0]            fifo_write_data1,
  output logic [31:0]            fifo_write_data2,
  output logic [31:0]            fifo_write_address1,
  output logic [31:0]            fifo_write_address2
`ifdef FETCH_SCHED_PERF_EN
  ,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_discards
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int IW = 2;

  typedef enum logic {StRun, StDrain} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [CW-1:0]   credits_q, credits_d;
  logic [IW-1:0]   inflight_q, inflight_d;
  logic [31:0]     q_addr_q [MAX_INFLIGHT];
  logic            alive_q;
  logic            flush_q;
  logic            we1_q, we2_q;
  logic [31:0]     wd1_q, wd2_q, wa1_q, wa2_q;

  logic            ic_req_c, hs, pop, keep, single;
  logic [IW-1:0]   push_idx;
  int              cred;

  // alive_q holds requests off while in reset; flush_q keeps the redirect target from issuing
  // in the same cycle as the FIFO flush.
  assign ic_req_c = alive_q && !flush_q && (state_q == StRun) && (credits_q >= CW'(2)) &&
                    (inflight_q < IW'(MAX_INFLIGHT)) && !redirect_valid;
  assign hs       = ic_req_c && ic.ic_ready;
  assign pop      = ic.ic_resp_valid && (inflight_q != '0);
  assign keep     = pop && (state_q == StRun) && !redirect_valid;
  assign single   = q_addr_q[0][2];
  assign push_idx = inflight_q - IW'(pop);

  assign ic.ic_req  = ic_req_c;
  assign ic.ic_addr = ic_req_c ? pc_q : '0;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    cred       = int'(credits_q);
    // Reads during the flush cycle hit entries that are being discarded; no credit for those.
    if (!flush_q && !fifo_empty) cred = cred + int'(fifo_read_en1) + int'(fifo_read_en2);
    if (pop) cred = cred + (keep ? int'(single) : 2);
    if (hs) cred = cred - 2;
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      inflight_d = inflight_q - IW'(pop);
      // FIFO is flushed, so only the still-outstanding requests hold reservations.
      cred       = int'(FIFO_DEPTH) - 2 * int'(inflight_d);
      state_d    = (inflight_d != '0) ? StDrain : StRun;
    end else begin
      inflight_d = inflight_q - IW'(pop) + IW'(hs);
      if (hs) pc_d = {pc_q[31:3], 3'b000} + 32'd8;
      if ((state_q == StDrain) && (inflight_d == '0)) state_d = StRun;
    end
    if (cred > int'(FIFO_DEPTH)) cred = int'(FIFO_DEPTH);
    if (cred < 0) cred = 0;
    credits_d = CW'(cred);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      credits_q  <= CW'(FIFO_DEPTH);
      inflight_q <= '0;
      alive_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      credits_q  <= credits_d;
      inflight_q <= inflight_d;
      alive_q    <= 1'b1;
      flush_q    <= redirect_valid;
    end
  end

  // In-flight address queue, oldest entry at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_INFLIGHT; i++) q_addr_q[i] <= '0;
    end else begin
      if (pop) begin
        for (int i = 0; i < MAX_INFLIGHT - 1; i++) q_addr_q[i] <= q_addr_q[i+1];
      end
      if (hs) q_addr_q[push_idx] <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we1_q <= 1'b0;
      we2_q <= 1'b0;
      wd1_q <= '0;
      wd2_q <= '0;
      wa1_q <= '0;
      wa2_q <= '0;
    end else begin
      we1_q <= keep;
      we2_q <= keep && !single;
      if (keep) begin
        wd1_q <= ic.ic_resp_data1;
        wd2_q <= ic.ic_resp_data2;
        wa1_q <= q_addr_q[0];
        wa2_q <= q_addr_q[0] + 32'd4;
      end
    end
  end

  assign fifo_flush          = flush_q;
  assign fifo_write_en1      = we1_q;
  assign fifo_write_en2      = we2_q;
  assign fifo_write_data1    = wd1_q;
  assign fifo_write_data2    = wd2_q;
  assign fifo_write_address1 = wa1_q;
  assign fifo_write_address2 = wa2_q;

`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] stall_q, disc_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      disc_q  <= '0;
    end else begin
      if (alive_q && (state_q == StRun) && (credits_q < CW'(2))) stall_q <= stall_q + 32'd1;
      if (pop && !keep) disc_q <= disc_q + 32'd1;
    end
  end

  assign perf_stall_cycles = stall_q;
  assign perf_discards     = disc_q;
`endif

endmodule

// File: tb/tb_fetch_scheduler.sv
module tb_fetch_scheduler;
  localparam int          Depth   = 16;
  localparam int          MaxInf  = 2;
  localparam logic [31:0] ResetPc = 32'hBFC0_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fifo_read_en1, fifo_read_en2, fifo_empty;
  logic        fifo_flush, fifo_write_en1, fifo_write_en2;
  logic [31:0] fifo_write_data1, fifo_write_data2, fifo_write_address1, fifo_write_address2;
`ifdef FETCH_SCHED_PERF_EN
  logic [31:0] perf_stall_cycles, perf_discards;
`endif

  always #5 clk = ~clk;

  fetch_scheduler_if ic_bus ();

  fetch_scheduler #(
    .RESET_PC     (ResetPc),
    .FIFO_DEPTH   (Depth),
    .MAX_INFLIGHT (MaxInf)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .redirect_valid      (redirect_valid),
    .redirect_pc         (redirect_pc),
    .ic                  (ic_bus),
    .fifo_read_en1       (fifo_read_en1),
    .fifo_read_en2       (fifo_read_en2),
    .fifo_empty          (fifo_empty),
    .fifo_flush          (fifo_flush),
    .fifo_write_en1      (fifo_write_en1),
    .fifo_write_en2      (fifo_write_en2),
    .fifo_write_data1    (fifo_write_data1),
    .fifo_write_data2    (fifo_write_data2),
    .fifo_write_address1 (fifo_write_address1),
    .fifo_write_address2 (fifo_write_address2)
`ifdef FETCH_SCHED_PERF_EN
    ,
    .perf_stall_cycles   (perf_stall_cycles),
    .perf_discards       (perf_discards)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: PC, credit pool, FIFO of outstanding request addresses, FIFO occupancy.
  logic [31:0] m_pc;
  int          m_credits;
  logic [31:0] m_q[$];
  bit          m_drain;
  int          fifo_cnt;
  bit          e_we1, e_we2, e_flush;
  logic [31:0] e_a, e_d1, e_d2;
  int          hs_cnt, words_cnt;

  task automatic model_reset();
    m_pc = ResetPc; m_credits = Depth; m_q.delete(); m_drain = 0; fifo_cnt = 0;
    e_we1 = 0; e_we2 = 0; e_flush = 0; e_a = '0; e_d1 = '0; e_d2 = '0;
  endtask

  task automatic drive_idle();
    redirect_valid = 0; redirect_pc = '0; ic_bus.ic_ready = 0; ic_bus.ic_resp_valid = 0;
    ic_bus.ic_resp_data1 = '0; ic_bus.ic_resp_data2 = '0;
    fifo_read_en1 = 0; fifo_read_en2 = 0; fifo_empty = 1;
  endtask

  // ready/resp modes: 0 off, 1 on (resp only when pending), 2 random.
  // rd_mode: 0 none, 1 read as much as possible, 2 random, 3 both strobes with fifo_empty forced.
  task automatic cycle(input bit f_redir, input logic [31:0] f_pc, input int ready_mode,
                       input int resp_mode, input int rd_mode);
    bit m_req, hs, nw1, nw2;
    int reads, cr;
    logic [31:0] a, na, nd1, nd2;
    @(negedge clk);
    check_val("write_en1", fifo_write_en1, e_we1);
    if (e_we1) begin
      check_val("write_addr1", fifo_write_address1, e_a);
      check_val("write_data1", fifo_write_data1, e_d1);
    end
    check_val("write_en2", fifo_write_en2, e_we2);
    if (e_we2) begin
      check_val("write_addr2", fifo_write_address2, e_a + 32'd4);
      check_val("write_data2", fifo_write_data2, e_d2);
    end
    check_val("fifo_flush", fifo_flush, e_flush);
    words_cnt += int'(fifo_write_en1) + int'(fifo_write_en2);

    redirect_valid = f_redir;
    redirect_pc    = f_pc;
    ic_bus.ic_ready = (ready_mode == 1) || (ready_mode == 2 && $urandom_range(0, 3) != 0);
    ic_bus.ic_resp_valid = (m_q.size() > 0) &&
                           (resp_mode == 1 || (resp_mode == 2 && $urandom_range(0, 1) == 1));
    ic_bus.ic_resp_data1 = $urandom;
    ic_bus.ic_resp_data2 = $urandom;
    fifo_empty = (fifo_cnt == 0);
    fifo_read_en1 = 0;
    fifo_read_en2 = 0;
    case (rd_mode)
      1: begin fifo_read_en1 = fifo_cnt >= 1; fifo_read_en2 = fifo_cnt >= 2; end
      2: begin
        if (fifo_empty) begin
          fifo_read_en1 = $urandom_range(0, 1) == 1;
          fifo_read_en2 = $urandom_range(0, 1) == 1;
        end else begin
          fifo_read_en1 = $urandom_range(0, 1) == 1;
          fifo_read_en2 = fifo_cnt >= 2 && $urandom_range(0, 1) == 1;
        end
      end
      3: begin fifo_empty = 1; fifo_read_en1 = 1; fifo_read_en2 = 1; end
      default: ;
    endcase
    #1;
    m_req = !e_flush && !m_drain && m_credits >= 2 && m_q.size() < MaxInf && !f_redir;
    check_val("ic_req", ic_bus.ic_req, m_req);
    if (m_req) check_val("ic_addr", ic_bus.ic_addr, m_pc);
    hs = m_req && ic_bus.ic_ready;
    if (ic_bus.ic_req && ic_bus.ic_ready) hs_cnt++;

    reads = fifo_empty ? 0 : int'(fifo_read_en1) + int'(fifo_read_en2);
    fifo_cnt = e_flush ? 0 : fifo_cnt - reads + int'(e_we1) + int'(e_we2);
    cr = e_flush ? 0 : reads;
    nw1 = 0; nw2 = 0; na = '0; nd1 = '0; nd2 = '0;
    if (ic_bus.ic_resp_valid) begin
      a = m_q.pop_front();
      if (!m_drain && !f_redir) begin
        nw1 = 1; na = a; nd1 = ic_bus.ic_resp_data1;
        nw2 = !a[2]; nd2 = ic_bus.ic_resp_data2;
        cr += a[2] ? 1 : 0;
      end else begin
        cr += 2;
      end
    end
    if (f_redir) begin
      m_credits = Depth - 2 * m_q.size();
      m_drain   = m_q.size() > 0;
      m_pc      = f_pc;
    end else begin
      m_credits += cr;
      if (hs) begin
        m_q.push_back(m_pc);
        m_credits -= 2;
        m_pc = {m_pc[31:3], 3'b000} + 32'd8;
      end
      if (m_drain && m_q.size() == 0) m_drain = 0;
    end
    if (nw1) begin e_a = na; e_d1 = nd1; end
    if (nw2) e_d2 = nd2;
    e_we1 = nw1; e_we2 = nw2; e_flush = f_redir;
  endtask

  initial begin
    drive_idle();
    model_reset();
    hs_cnt = 0; words_cnt = 0;
    #12;
    check_val("reset_ic_req", ic_bus.ic_req, 0);
    check_val("reset_write_en1", fifo_write_en1, 0);
    check_val("reset_flush", fifo_flush, 0);
    @(negedge clk); #2 rst_n = 1;

    // Fill: always ready, response one cycle after accept, no reads.
    repeat (24) cycle(0, '0, 1, 1, 0);
    check_val("fill_handshakes", hs_cnt, 8);
    check_val("fill_words", words_cnt, 16);

    // Full FIFO: masked strobes give nothing, real reads return 2 credits.
    cycle(0, '0, 0, 0, 3);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);

    // Redirect to an odd word: single-slot write, next fetch 8-aligned.
    cycle(1, 32'h8000_0004, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 0, 1, 0);
    cycle(0, '0, 0, 0, 0);

    // Two in flight, redirect, drain both.
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(1, 32'h8000_1000, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 1, 0);
    cycle(0, '0, 1, 1, 0);
    cycle(0, '0, 0, 0, 0);

    // Redirect coincident with the only outstanding response.
    cycle(0, '0, 1, 0, 0);
    cycle(1, 32'h8000_2000, 0, 1, 1);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);

    // Randomized traffic.
    repeat (3000) begin
      logic [31:0] t;
      t = $urandom;
      cycle($urandom_range(0, 19) == 0, {t[31:2], 2'b00}, 2, 2, 2);
    end

    // Get into DRAIN, then assert reset between edges.
    for (int i = 0; i < 20 && !m_drain; i++) begin
      cycle(m_q.size() == MaxInf, 32'h8000_3000, 1, 0, 1);
    end
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    check_val("async_rst_ic_req", ic_bus.ic_req, 0);
    check_val("async_rst_ic_addr", ic_bus.ic_addr, 0);
    check_val("async_rst_we1", fifo_write_en1, 0);
    check_val("async_rst_we2", fifo_write_en2, 0);
    check_val("async_rst_flush", fifo_flush, 0);
    drive_idle();
    @(negedge clk); #2 rst_n = 1;
    model_reset();
    cycle(0, '0, 0, 0, 0);
    check_val("addr_after_reset", ic_bus.ic_addr, ResetPc);
    repeat (200) cycle(0, '0, 2, 2, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_scheduler.md
# fetch_scheduler

Front-end controller that sequences instruction-cache fetch requests and writes returned instructions into the 16-entry instruction FIFO. It issues dual-word fetches from a local PC and reserves FIFO space with a credit counter so a response always has room. On a branch redirect it flushes the FIFO and discards stale in-flight responses. It sits between the PC/branch unit, the I-cache port and the instruction FIFO write side.

## Interface
- RESET_PC, 32'hBFC0_0000, first fetch address after reset
- FIFO_DEPTH, 16, instruction FIFO capacity in words; initial credit value
- MAX_INFLIGHT, 2, maximum accepted-but-unanswered I-cache requests (1..3)

Ports:
- clk  in  1  clock, all logic on posedge
- rst_n  in  1  reset; asynchronous, active-low
- redirect_valid  in  1  branch/exception redirect, single-cycle pulse
- redirect_pc  in  32  redirect target, word aligned
- ic_req  out  1  fetch request valid
- ic_addr  out  32  fetch address (current PC)
- ic_ready  in  1  I-cache accepts; handshake = ic_req && ic_ready
- ic_resp_valid  in  1  response for the oldest in-flight request; in order
- ic_resp_data1 / ic_resp_data2  in  32 each  instruction at ic_addr / ic_addr+4
- fifo_read_en1 / fifo_read_en2  in  1 each  FIFO read strobes from issue
- fifo_empty  in  1  FIFO empty flag; masks read strobes
- fifo_flush  out  1  one-cycle FIFO reset pulse
- fifo_write_en1 / fifo_write_en2  out  1 each
- fifo_write_data1 / fifo_write_data2  out  32 each
- fifo_write_address1 / fifo_write_address2  out  32 each

## Operation
- States: RUN, DRAIN. Reset: RUN, pc=RESET_PC, credits=FIFO_DEPTH, inflight=0, all outputs 0.
- Credit counter, 5 bits, range 0..FIFO_DEPTH: reserve 2 per accepted request; return 1 per effective read (fifo_read_enN && !fifo_empty); return 1 for unused slot2 (pc[2]==1); return 2 per discarded response.
- ic_req = state==RUN && credits>=2 && inflight<MAX_INFLIGHT && !redirect_valid.
- On handshake: pc <= {pc[31:3],3'b0}+8, inflight++ and a 1-bit "single" flag (ic_addr[2]) and the address are pushed into an in-flight queue of depth MAX_INFLIGHT.
- On ic_resp_valid in RUN (no redirect that cycle): pop queue; write_en1=1 with data1/addr; write_en2=!single with data2/addr+4.
- redirect_valid (any state): fifo_flush pulse; credits <= FIFO_DEPTH − 2·(inflight after this cycle's pop/push); pc <= redirect_pc; all remaining in-flight entries marked stale; state <= DRAIN if any stale remain, else RUN.
- DRAIN: ic_req=0; every response popped, discarded (no FIFO write), credits +=2; when last stale pops, -> RUN next cycle. A further redirect in DRAIN only retargets pc.
- Simultaneous redirect and response: response is discarded (counts as stale).
- Reset mid-operation: all state cleared asynchronously; outstanding I-cache responses after reset are the I-cache's responsibility to cancel.

## Timing
- ic_req/ic_addr combinational from registered state; new request may issue every cycle.
- Response -> FIFO write: 1 cycle (write outputs registered).
- redirect_valid -> fifo_flush: 1 cycle (registered); first request to redirect_pc no earlier than the cycle after fifo_flush.
- Credits updated same edge as causing event; read returns usable next cycle.
- Credits never exceed FIFO_DEPTH nor go below 0; inflight never exceeds MAX_INFLIGHT.

## Configuration
- FETCH_SCHED_PERF_EN: defined -> adds outputs perf_stall_cycles[31:0] (cycles in RUN with ic_req=0 due to credits<2) and perf_discards[31:0] (discarded responses); both wrap, reset to 0. Undefined -> ports and counters absent, behaviour otherwise identical.

## Test plan
- Reset, ic_ready=1, response 1 cycle after each accept, no reads -> addresses BFC00000, BFC00008, …; 8 request handshakes then ic_req=0 with 16 words written, credits=0.
- redirect_pc=0x80000004, one response -> one write (addr 80000004), write_en2=0, next ic_addr=80000008, credits returned 1 for slot2.
- Two requests in flight, redirect to 0x80001000 -> fifo_flush next cycle, both responses dropped, ic_req stays 0 until second drop, then ic_addr=80001000.
- Redirect in same cycle as ic_resp_valid with inflight=1 -> no FIFO write, state RUN next cycle, credits=16.
- FIFO full (credits 0), fifo_read_en1&fifo_read_en2 with fifo_empty=0 -> credits 2, ic_req high next cycle; same strobes with fifo_empty=1 -> credits unchanged.
- rst_n low mid-DRAIN, asynchronous -> all outputs 0 immediately, ic_addr=BFC00000 after release.
